sram_ctl: RTL and testbench



---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_bank.sv | 47 ++++
 rtl/sram_ctl.sv | 73 +++++++
 tb/tb_sram_ctl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared widths, defaults and word/address types for sram_ctl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;
  localparam int DATA_W        = 64;
  localparam int ADDR_W        = 23;
  localparam int DEF_DEPTH     = 1024;
  localparam int DEF_NUM_BANKS = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

`default_nettype wire

// File: rtl/sram_bank.sv
// ============================================================================
// Module      : sram_bank
// Description : One SRAM bank: word storage plus per-row valid bits that
//               clear synchronously on reset. Read data is combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank
  import sram_pkg::*;
#(
  parameter int ROWS  = 256,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ROW_W-1:0] row,
  input  word_t            wdata,
  output word_t            rdata,
  output logic             rvalid
);

  word_t             r_mem [ROWS];
  logic [ROWS-1:0]   r_valid;

  // Contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      r_mem[row] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (we) begin
      r_valid[row] <= 1'b1;
    end
  end

  assign rdata  = r_mem[row];
  assign rvalid = r_valid[row];

endmodule

`default_nettype wire

// File: rtl/sram_ctl.sv
// ============================================================================
// Module      : sram_ctl
// Description : Single-port banked SRAM with registered read port; unwritten
//               words read as zero after reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_ctl
  import sram_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_BANKS = DEF_NUM_BANKS
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t data_in,
  input  addr_t address,
  input  logic  write_en,
  output word_t data_out
);

  localparam int c_IDX_W  = $clog2(DEPTH);
  localparam int c_BANK_W = $clog2(NUM_BANKS);
  localparam int c_ROWS   = DEPTH / NUM_BANKS;
  localparam int c_ROW_W  = c_IDX_W - c_BANK_W;

  logic [c_IDX_W-1:0]  w_index;
  logic [c_BANK_W-1:0] w_bank;
  logic [c_ROW_W-1:0]  w_row;
  word_t               w_rdata  [NUM_BANKS];
  logic [NUM_BANKS-1:0] w_rvalid;
  word_t               w_rd_sel;
  word_t               r_data_out;
  logic                w_unused_addr;

  // Upper address bits alias onto the implemented depth.
  assign w_index       = address[c_IDX_W-1:0];
  assign w_unused_addr = ^address[ADDR_W-1:c_IDX_W];
  assign w_bank        = w_index[c_BANK_W-1:0];
  assign w_row         = w_index[c_IDX_W-1:c_BANK_W];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sram_bank #(
      .ROWS  (c_ROWS),
      .ROW_W (c_ROW_W)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (write_en && (w_bank == c_BANK_W'(b))),
      .row    (w_row),
      .wdata  (data_in),
      .rdata  (w_rdata[b]),
      .rvalid (w_rvalid[b])
    );
  end

  assign w_rd_sel = w_rvalid[w_bank] ? w_rdata[w_bank] : '0;

  // Writes leave the read register untouched (no write-through).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (!write_en) begin
      r_data_out <= w_rd_sel;
    end
  end

  assign data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_sram_ctl.sv
// ============================================================================
// Module      : tb_sram_ctl
// Description : Self-checking bench for sram_ctl against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_ctl;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic [22:0] address;
  logic        write_en;
  logic [63:0] data_out;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [63:0] m_mem [1024];
  bit          m_val [1024];
  logic [63:0] m_out;

  sram_ctl dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .address  (address),
    .write_en (write_en),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model advances with the same edge.
  task automatic step(input logic r, input logic we, input logic [22:0] a,
                      input logic [63:0] d);
    int idx;
    @(negedge clk);
    rst = r; write_en = we; address = a; data_in = d;
    @(posedge clk);
    idx = int'(a) % 1024;
    if (r) begin
      m_out = 64'd0;
      for (int i = 0; i < 1024; i++) m_val[i] = 1'b0;
    end else if (we) begin
      m_mem[idx] = d;
      m_val[idx] = 1'b1;
    end else begin
      m_out = m_val[idx] ? m_mem[idx] : 64'd0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 23'd0, 64'h0123456789ABCDEF);
    checks_total++;
    if (data_out !== 64'd0) $display("FAIL reset_out: got %h want %h", data_out, 64'd0);
    else checks_passed++;
    step(1'b0, 1'b0, 23'd0, 64'd0);
    checks_total++;
    if (data_out !== 64'd0) $display("FAIL reset_write_suppressed: got %h want %h", data_out, 64'd0);
    else checks_passed++;
  endtask

  task automatic test_unwritten();
    step(1'b0, 1'b0, 23'd500, 64'd0);
    checks_total++;
    if (data_out !== 64'd0) $display("FAIL unwritten_500: got %h want %h", data_out, 64'd0);
    else checks_passed++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 23'(i), 64'h1122334455667788 + 64'(i));
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 23'(i), 64'd0);
      checks_total++;
      if (data_out !== 64'h1122334455667788 + 64'(i))
        $display("FAIL fill_read[%0d]: got %h want %h", i, data_out, 64'h1122334455667788 + 64'(i));
      else checks_passed++;
    end
  endtask

  task automatic test_alias();
    step(1'b0, 1'b1, 23'h000405, 64'hDEADBEEF00000001);
    step(1'b0, 1'b0, 23'd5, 64'd0);
    checks_total++;
    if (data_out !== 64'hDEADBEEF00000001)
      $display("FAIL alias_read: got %h want %h", data_out, 64'hDEADBEEF00000001);
    else checks_passed++;
  endtask

  task automatic test_overwrite();
    step(1'b0, 1'b1, 23'd7, 64'hAAAA);
    checks_total++;
    if (data_out !== 64'hDEADBEEF00000001)
      $display("FAIL hold_write1: got %h want %h", data_out, 64'hDEADBEEF00000001);
    else checks_passed++;
    step(1'b0, 1'b1, 23'd7, 64'hBBBB);
    checks_total++;
    if (data_out !== 64'hDEADBEEF00000001)
      $display("FAIL hold_write2: got %h want %h", data_out, 64'hDEADBEEF00000001);
    else checks_passed++;
    step(1'b0, 1'b0, 23'd7, 64'd0);
    checks_total++;
    if (data_out !== 64'hBBBB) $display("FAIL overwrite_read: got %h want %h", data_out, 64'hBBBB);
    else checks_passed++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 23'd0, 64'd0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 23'(i), 64'd0);
      checks_total++;
      if (data_out !== 64'd0) $display("FAIL reset_mid_read[%0d]: got %h want %h", i, data_out, 64'd0);
      else checks_passed++;
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, 23'd9, 64'hCAFEF00D12345678);
    step(1'b0, 1'b0, 23'd9, 64'd0);
    checks_total++;
    if (data_out !== 64'hCAFEF00D12345678)
      $display("FAIL back_to_back: got %h want %h", data_out, 64'hCAFEF00D12345678);
    else checks_passed++;
  endtask

  task automatic test_random();
    logic        r, we;
    logic [22:0] a;
    logic [63:0] d;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 39) == 0);
      we = $urandom_range(0, 1) == 1;
      a  = 23'(($urandom & 32'h007F_FC00) | $urandom_range(0, 63));
      d  = {$urandom, $urandom};
      step(r, we, a, d);
      checks_total++;
      if (data_out !== m_out)
        $display("FAIL random[%0d]: addr %h got %h want %h", n, a, data_out, m_out);
      else checks_passed++;
      // Mid-cycle input noise must not disturb anything.
      address = 23'($urandom); data_in = {$urandom, $urandom};
      write_en = $urandom_range(0, 1) == 1;
    end
  endtask

  initial begin
    rst = 1'b0; write_en = 1'b0; address = '0; data_in = '0; m_out = '0;
    for (int i = 0; i < 1024; i++) begin m_val[i] = 1'b0; m_mem[i] = '0; end
    test_reset();
    test_unwritten();
    test_fill();
    test_alias();
    test_overwrite();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

`default_nettype wire
